regfile_write_scheduler: RTL and testbench

Shares the register file's single write port between two producers: the in-order pipeline writeback stage, which can never be back-pressured, and a multi-cycle unit (mul/div, with a valid/ready handshake). The block arbitrates the two and drives the register file's `en`/`rd`/`data` write inputs through a registered stage. It forces a one-cycle pipeline bubble when the multi-cycle unit starves. It also keeps a scoreboard of destinations with outstanding multi-cycle results and flags hazards on the decode-stage `rs`/`rt` read addresses.

---
 rtl/lapido_rf_pkg.sv | 17 +
 rtl/regfile_write_scheduler_scoreboard.sv | 34 +++
 rtl/regfile_write_scheduler.sv | 115 +++++++++++
 tb/tb_regfile_write_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lapido_rf_pkg.sv
// Shared types and constants for the register-file write scheduler.
package lapido_rf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    typedef enum logic {
        SRC_WB = 1'b0,
        SRC_MC = 1'b1
    } src_t;
endpackage

// File: rtl/regfile_write_scheduler_scoreboard.sv
// Pending-write bit vector for multi-cycle destinations.
module reg_scoreboard
    import lapido_rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hit_rs,
    output logic                  hit_rt
);
    logic [REG_COUNT-1:0] pending;
    logic [REG_COUNT-1:0] pending_nx;

    // Clear first so a same-cycle set of the same index wins.
    always_comb begin
        pending_nx = pending;
        if (clr_en) pending_nx[clr_idx] = 1'b0;
        if (set_en) pending_nx[set_idx] = 1'b1;
        pending_nx[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nx;
    end

    assign hit_rs = pending[rs];
    assign hit_rt = pending[rt];
endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the register-file write port between writeback and a
// multi-cycle unit, with starvation bubble and pending-write scoreboard.
module regfile_write_scheduler
    import lapido_rf_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  mc_valid,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    input  logic [DATA_W-1:0]     mc_data,
    output logic                  mc_ready,
    input  logic                  mc_issue,
    input  logic [REG_ADDR_W-1:0] mc_issue_rd,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rt,
    output logic                  hazard_rs,
    output logic                  hazard_rt,
    output logic                  stall_pipe,
    output logic                  rf_en,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0]     rf_data
);
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    src_t       src;
    logic       transfer;

    assign mc_ready   = ~wb_en & ~rst;
    assign transfer   = mc_valid & mc_ready;
    assign stall_pipe = (state == ST_FORCE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            ST_IDLE: begin
                if (mc_valid && wb_en) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = 4'd1;
                end
            end
            ST_WAIT: begin
                if (!mc_valid || transfer) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end else begin
                    if (cnt == MAX_W) state_nx = ST_FORCE;
                    if (cnt != 4'hf)  cnt_nx = cnt + 4'd1;
                end
            end
            ST_FORCE: begin
                // A writeback that ignores the stall still wins; keep forcing.
                if (!mc_valid || transfer) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 4'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en   <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
            src     <= SRC_WB;
        end else if (wb_en) begin
            rf_en   <= (wb_rd != '0);
            rf_rd   <= wb_rd;
            rf_data <= wb_data;
            src     <= SRC_WB;
        end else if (transfer) begin
            rf_en   <= (mc_rd != '0);
            rf_rd   <= mc_rd;
            rf_data <= mc_data;
            src     <= SRC_MC;
        end else begin
            rf_en   <= 1'b0;
        end
    end

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (mc_issue),
        .set_idx (mc_issue_rd),
        .clr_en  (rf_en && (src == SRC_MC)),
        .clr_idx (rf_rd),
        .rs      (rs),
        .rt      (rt),
        .hit_rs  (hazard_rs),
        .hit_rt  (hazard_rt)
    );
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed and randomized bench for regfile_write_scheduler with a
// cycle-level reference model.
module tb_regfile_write_scheduler;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_rd = '0;
    logic [31:0] mc_data = '0;
    logic        mc_ready;
    logic        mc_issue = 1'b0;
    logic [4:0]  mc_issue_rd = '0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic        hazard_rs, hazard_rt, stall_pipe;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    bit [31:0]   pend;
    int          streak;
    bit          mforce;
    bit          e_en;
    bit          e_src_mc;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    bit          m_xfer;

    always #5 clk = ~clk;

    regfile_write_scheduler #(.MAX_WAIT(MAXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mc_valid    (mc_valid),
        .mc_rd       (mc_rd),
        .mc_data     (mc_data),
        .mc_ready    (mc_ready),
        .mc_issue    (mc_issue),
        .mc_issue_rd (mc_issue_rd),
        .rs          (rs),
        .rt          (rt),
        .hazard_rs   (hazard_rs),
        .hazard_rt   (hazard_rt),
        .stall_pipe  (stall_pipe),
        .rf_en       (rf_en),
        .rf_rd       (rf_rd),
        .rf_data     (rf_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend = '0; streak = 0; mforce = 0;
        e_en = 0; e_src_mc = 0; e_rd = '0; e_data = '0;
    endtask

    // One clock: check combinational outputs, advance model, check registers.
    task automatic step();
        bit xfer;
        #1;
        chk("mc_ready", 32'(mc_ready), 32'(!wb_en && !rst));
        chk("hazard_rs", 32'(hazard_rs), 32'(pend[rs]));
        chk("hazard_rt", 32'(hazard_rt), 32'(pend[rt]));
        chk("stall_pre", 32'(stall_pipe), 32'(mforce));
        xfer = mc_valid && !wb_en && !rst;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (e_en && e_src_mc) pend[e_rd] = 1'b0;
            if (mc_issue && mc_issue_rd != 0) pend[mc_issue_rd] = 1'b1;
            if (wb_en) begin
                e_en = (wb_rd != 0); e_rd = wb_rd;
                e_data = wb_data; e_src_mc = 0;
            end else if (xfer) begin
                e_en = (mc_rd != 0); e_rd = mc_rd;
                e_data = mc_data; e_src_mc = 1;
            end else begin
                e_en = 0;
            end
            // Bubble once the unit has been blocked more than MAXW cycles.
            if (!mc_valid || xfer) begin
                streak = 0; mforce = 0;
            end else begin
                streak++;
                if (streak > MAXW) mforce = 1;
            end
        end
        m_xfer = xfer;
        #1;
        chk("rf_en", 32'(rf_en), 32'(e_en));
        if (e_en) begin
            chk("rf_rd", 32'(rf_rd), 32'(e_rd));
            chk("rf_data", rf_data, e_data);
        end
        chk("stall_post", 32'(stall_pipe), 32'(mforce));
    endtask

    initial begin
        model_reset();
        // Reset held 3 cycles with both producers requesting
        rst = 1; wb_en = 1; wb_rd = 5'd1; mc_valid = 1; mc_rd = 5'd2;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_data", rf_data, 32'd0);
        rst = 0; wb_en = 0; mc_valid = 0;
        step();

        // Pipeline priority
        wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
        mc_valid = 1; mc_rd = 5'd6; mc_data = 32'h66;
        #1 chk("prio_ready", 32'(mc_ready), 32'd0);
        step();
        chk("prio_rd", 32'(rf_rd), 32'd5);
        chk("prio_data", rf_data, 32'hDEADBEEF);
        mc_valid = 0; wb_en = 0;
        step();

        // Starvation: stall after MAXW+1 blocked cycles
        wb_en = 1; wb_rd = 5'd4; mc_valid = 1; mc_rd = 5'd7;
        mc_data = 32'h7777;
        for (int i = 0; i < MAXW + 1; i++) begin
            chk("starve_nostall", 32'(stall_pipe), 32'd0);
            step();
        end
        chk("starve_stall", 32'(stall_pipe), 32'd1);
        wb_en = 0;
        step();
        chk("starve_xfer_rd", 32'(rf_rd), 32'd7);
        chk("starve_release", 32'(stall_pipe), 32'd0);
        mc_valid = 0;
        step();

        // Scoreboard set, read, clear
        mc_issue = 1; mc_issue_rd = 5'd9;
        step();
        mc_issue = 0; rs = 5'd9; rt = 5'd9;
        #1 chk("sb_rs9", 32'(hazard_rs), 32'd1);
        chk("sb_rt9", 32'(hazard_rt), 32'd1);
        mc_valid = 1; mc_rd = 5'd9; mc_data = 32'h99;
        step();
        mc_valid = 0;
        step();
        step();
        chk("sb_clr9", 32'(hazard_rs), 32'd0);

        // Register zero
        mc_issue = 1; mc_issue_rd = 5'd0; rs = 5'd0;
        step();
        mc_issue = 0;
        #1 chk("r0_haz", 32'(hazard_rs), 32'd0);
        mc_valid = 1; mc_rd = 5'd0; mc_data = 32'h1234;
        step();
        chk("r0_noen", 32'(rf_en), 32'd0);
        mc_valid = 0;
        step();

        // Simultaneous set and clear of r3
        mc_issue = 1; mc_issue_rd = 5'd3;
        step();
        mc_issue = 0; mc_valid = 1; mc_rd = 5'd3; mc_data = 32'h33;
        step();
        mc_valid = 0; mc_issue = 1; mc_issue_rd = 5'd3; rs = 5'd3;
        step();
        mc_issue = 0;
        #1 chk("setclr_r3", 32'(hazard_rs), 32'd1);
        step();

        // Randomized traffic under the model
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (m_xfer || !mc_valid) begin
                mc_valid = ($urandom_range(0, 2) != 0);
                mc_rd    = 5'($urandom_range(0, 7));
                mc_data  = $urandom;
            end else if ($urandom_range(0, 19) == 0) begin
                mc_valid = 0;
            end
            if (mforce) wb_en = ($urandom_range(0, 9) == 0);
            else        wb_en = ($urandom_range(0, 9) < 7);
            wb_rd       = 5'($urandom_range(0, 31));
            wb_data     = $urandom;
            mc_issue    = ($urandom_range(0, 2) == 0);
            mc_issue_rd = 5'($urandom_range(0, 7));
            rs          = 5'($urandom_range(0, 7));
            rt          = 5'($urandom_range(0, 7));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
